// File: rtl/stack_unit.sv
// Hardware call/return stack: saves {pc, flags} frames into data memory below STACK_TOP
// through an arbitrated data bus, and restores them on pop.
module stack_unit #(
  parameter logic [7:0] STACK_TOP = 8'hFF,
  parameter int         DEPTH     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stack_op_ongoing,
  input  logic       push_or_pop,
  input  logic [7:0] pc_in,
  input  logic [5:0] flags_in,
  output logic       stack_op_end,
  output logic [7:0] return_addr,
  output logic [5:0] flags_out,
  output logic       bus_req,
  input  logic       bus_grant,
  output logic [7:0] mem_addr,
  output logic       mem_wr,
  output logic       mem_rd,
  output logic [7:0] mem_dout,
  input  logic [7:0] mem_din,
  output logic [7:0] sp,
  output logic       stk_err
);

  localparam int DW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {IDLE, REQ, ACC0, ACC1, END} state_t;

  state_t        state_r, state_s;
  logic          push_r;
  logic [7:0]    pc_r;
  logic [5:0]    flags_r;
  logic [7:0]    sp_r;
  logic [DW-1:0] depth_r;
  logic [7:0]    ret_r;
  logic [5:0]    flg_r;
  logic          err_r;
  logic          err_pend_r;
  logic          full_s, empty_s, bad_s, access_s;

  assign full_s   = (depth_r == DW'(DEPTH));
  assign empty_s  = (depth_r == {DW{1'b0}});
  assign bad_s    = push_or_pop ? full_s : empty_s;
  assign access_s = ((state_r == ACC0) || (state_r == ACC1)) && bus_grant;

  assign sp          = sp_r;
  assign return_addr = ret_r;
  assign flags_out   = flg_r;
  assign stk_err     = err_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_r <= IDLE;
    else      state_r <= state_s;
  end

  // Next-state logic; a rejected request spends one extra IDLE cycle so stk_err is
  // already visible when the completion pulse arrives.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (err_pend_r)                      state_s = END;
        else if (stack_op_ongoing && !bad_s) state_s = REQ;
        else                                 state_s = IDLE;
      end
      REQ:     state_s = bus_grant ? ACC0 : REQ;
      ACC0:    state_s = bus_grant ? ACC1 : ACC0;
      ACC1:    state_s = bus_grant ? END  : ACC1;
      END:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request latching, stack pointer/depth bookkeeping and restored-frame capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_r     <= 1'b0;
      pc_r       <= 8'h00;
      flags_r    <= 6'h00;
      sp_r       <= STACK_TOP;
      depth_r    <= {DW{1'b0}};
      ret_r      <= 8'h00;
      flg_r      <= 6'h00;
      err_r      <= 1'b0;
      err_pend_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (err_pend_r) begin
            err_pend_r <= 1'b0;
          end else if (stack_op_ongoing) begin
            if (bad_s) begin
              err_pend_r <= 1'b1;
              err_r      <= 1'b1;
            end else begin
              push_r  <= push_or_pop;
              pc_r    <= pc_in;
              flags_r <= flags_in;
            end
          end
        end
        ACC0: begin
          if (bus_grant && !push_r) flg_r <= mem_din[5:0];
        end
        ACC1: begin
          if (bus_grant) begin
            if (push_r) begin
              sp_r    <= sp_r - 8'd2;
              depth_r <= depth_r + DW'(1);
            end else begin
              ret_r   <= mem_din;
              sp_r    <= sp_r + 8'd2;
              depth_r <= depth_r - DW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Bus/memory outputs decoded from state; address and data stay 0 when idle so
  // several masters can share an OR-combined bus.
  always_comb begin
    bus_req      = (state_r == REQ) || (state_r == ACC0) || (state_r == ACC1);
    stack_op_end = (state_r == END);
    mem_wr       = access_s && push_r;
    mem_rd       = access_s && !push_r;
    mem_addr     = 8'h00;
    mem_dout     = 8'h00;
    if (access_s) begin
      if (state_r == ACC0) begin
        mem_addr = push_r ? sp_r : (sp_r + 8'd1);
        mem_dout = push_r ? pc_r : 8'h00;
      end else begin
        mem_addr = push_r ? (sp_r - 8'd1) : (sp_r + 8'd2);
        mem_dout = push_r ? {2'b00, flags_r} : 8'h00;
      end
    end else begin
      mem_addr = 8'h00;
      mem_dout = 8'h00;
    end
  end

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: a byte-wide memory model on the data bus and
// hand-computed expectations for push/pop, overflow/underflow, grant stalls and reset.
module tb_stack_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       stack_op_ongoing = 1'b0;
  logic       push_or_pop = 1'b0;
  logic [7:0] pc_in = 8'h00;
  logic [5:0] flags_in = 6'h00;
  logic       stack_op_end;
  logic [7:0] return_addr;
  logic [5:0] flags_out;
  logic       bus_req;
  logic       bus_grant = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr, mem_rd;
  logic [7:0] mem_dout, mem_din;
  logic [7:0] sp;
  logic       stk_err;

  logic [7:0] mem [256];
  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int rd_count = 0;
  int bad_acc  = 0;
  int lat;
  int wr_snap, rd_snap;

  stack_unit #(.STACK_TOP(8'hFF), .DEPTH(16)) dut (
    .clk(clk), .rst(rst),
    .stack_op_ongoing(stack_op_ongoing), .push_or_pop(push_or_pop),
    .pc_in(pc_in), .flags_in(flags_in),
    .stack_op_end(stack_op_end), .return_addr(return_addr), .flags_out(flags_out),
    .bus_req(bus_req), .bus_grant(bus_grant),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_dout(mem_dout), .mem_din(mem_din),
    .sp(sp), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  assign mem_din = mem[mem_addr];

  // Memory model plus access bookkeeping
  always @(posedge clk) begin
    if (mem_wr) begin
      mem[mem_addr] <= mem_dout;
      wr_count <= wr_count + 1;
    end
    if (mem_rd) rd_count <= rd_count + 1;
    if ((mem_wr || mem_rd) && !bus_grant) bad_acc <= bad_acc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one request; lat = rising edges from the sampling edge to the one that
  // raises stack_op_end (-1 on timeout). Grant is low in cycles 1..gdelay and gdrop.
  task automatic run_op(input logic push, input logic [7:0] pc, input logic [5:0] fl,
                        input int gdelay, input int gdrop, output int lat_o);
    int n;
    @(negedge clk);
    stack_op_ongoing = 1'b1;
    push_or_pop = push;
    pc_in = pc;
    flags_in = fl;
    bus_grant = 1'b1;
    n = 0;
    lat_o = -1;
    while (n < 40 && lat_o < 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (stack_op_end) lat_o = n;
      else bus_grant = !((n >= 1 && n <= gdelay) || n == gdrop);
    end
    stack_op_ongoing = 1'b0;
    bus_grant = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #12;
    check_eq("rst_sp", sp, 8'hFF);
    check_eq("rst_outs", {stk_err, stack_op_end, bus_req, mem_wr, mem_rd},
             5'b00000);
    check_eq("rst_bus", {mem_addr, mem_dout}, 16'h0000);
    check_eq("rst_ret", {return_addr, 2'b00, flags_out}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // Underflow pop from empty stack
    wr_snap = wr_count; rd_snap = rd_count;
    run_op(1'b0, 8'h00, 6'h00, 0, 0, lat);
    check_eq("uf_lat", lat, 2);
    check_eq("uf_err", stk_err, 1'b1);
    check_eq("uf_ret", return_addr, 8'h00);
    check_eq("uf_sp", sp, 8'hFF);
    check_eq("uf_noacc", (wr_count - wr_snap) + (rd_count - rd_snap), 0);

    // Basic push then pop
    pulse_reset();
    check_eq("err_cleared", stk_err, 1'b0);
    run_op(1'b1, 8'h3A, 6'h15, 0, 0, lat);
    check_eq("push_lat", lat, 4);
    check_eq("push_mem_ff", mem[8'hFF], 8'h3A);
    check_eq("push_mem_fe", mem[8'hFE], 8'h15);
    check_eq("push_sp", sp, 8'hFD);
    run_op(1'b0, 8'h00, 6'h00, 0, 0, lat);
    check_eq("pop_lat", lat, 4);
    check_eq("pop_flags", flags_out, 6'h15);
    check_eq("pop_ret", return_addr, 8'h3A);
    check_eq("pop_sp", sp, 8'hFF);
    check_eq("pop_err", stk_err, 1'b0);

    // Fill to DEPTH, then one push too many
    for (int i = 0; i < 16; i++) begin
      run_op(1'b1, 8'h40 + 8'(i), 6'(i), 0, 0, lat);
      check_eq("fill_lat", lat, 4);
    end
    check_eq("full_sp", sp, 8'hDF);
    check_eq("full_mem_e1", mem[8'hE1], 8'h4F);
    check_eq("full_mem_e0", mem[8'hE0], 8'h0F);
    check_eq("full_err", stk_err, 1'b0);
    wr_snap = wr_count;
    run_op(1'b1, 8'hEE, 6'h3F, 0, 0, lat);
    check_eq("of_lat", lat, 2);
    check_eq("of_err", stk_err, 1'b1);
    check_eq("of_nowr", wr_count - wr_snap, 0);
    check_eq("of_sp", sp, 8'hDF);
    run_op(1'b0, 8'h00, 6'h00, 0, 0, lat);
    check_eq("of_pop_ret", return_addr, 8'h4F);
    check_eq("of_pop_flags", flags_out, 6'h0F);
    check_eq("of_pop_sp", sp, 8'hE1);
    check_eq("err_sticky", stk_err, 1'b1);

    // Grant delayed three cycles and withdrawn for one cycle in ACC1
    pulse_reset();
    bad_acc = 0;
    run_op(1'b1, 8'hA5, 6'h2A, 3, 6, lat);
    check_eq("stall_lat", lat, 8);
    check_eq("stall_mem_ff", mem[8'hFF], 8'hA5);
    check_eq("stall_mem_fe", mem[8'hFE], 8'h2A);
    check_eq("stall_sp", sp, 8'hFD);
    check_eq("stall_noacc", bad_acc, 0);

    // Reset asserted while a push sits in ACC1
    pulse_reset();
    @(negedge clk);
    stack_op_ongoing = 1'b1; push_or_pop = 1'b1; pc_in = 8'h77; flags_in = 6'h11;
    bus_grant = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("acc1_active", {bus_req, mem_wr, mem_addr}, {2'b11, 8'hFE});
    rst = 1'b0;
    stack_op_ongoing = 1'b0;
    #1;
    check_eq("mid_rst_outs", {stack_op_end, bus_req, mem_wr, mem_rd, stk_err}, 5'b00000);
    check_eq("mid_rst_bus", {mem_addr, mem_dout}, 16'h0000);
    check_eq("mid_rst_sp", sp, 8'hFF);
    @(negedge clk);
    rst = 1'b1;
    wr_snap = wr_count;
    repeat (4) @(negedge clk);
    check_eq("post_rst_nowr", wr_count - wr_snap, 0);
    check_eq("post_rst_sp", sp, 8'hFF);
    check_eq("post_rst_ret", {return_addr, 2'b00, flags_out}, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
